// File: rtl/seq_divider_16bit_pkg.sv
// seq_divider_16bit_pkg: shared width default, FSM encoding and step-counter sizing for the divider.
package seq_divider_16bit_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/seq_divider_16bit_div_sub_step.sv
// div_sub_step: one restoring-division trial subtract of the divisor from the shifted partial remainder.
module div_sub_step
    import seq_divider_16bit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   i_remainder,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_difference,
    output logic             o_borrow
);

    logic [WIDTH+1:0] w_full;

    assign w_full       = {1'b0, i_remainder} - {2'b00, i_divisor};
    assign o_difference = w_full[WIDTH:0];
    assign o_borrow     = w_full[WIDTH+1];

endmodule

// File: rtl/seq_divider_16bit.sv
// seq_divider_16bit: multi-cycle restoring divider, one quotient bit per clock.
// Define SIGNED_DIV_EN for two's-complement operands (magnitude divide plus sign fix-up in FIN).
module seq_divider_16bit
    import seq_divider_16bit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV0
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_div0;
    logic             r_zero;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

`ifdef SIGNED_DIV_EN
    logic r_neg_q;
    logic r_neg_r;

    assign w_a_mag = A[WIDTH-1] ? -A : A;
    assign w_b_mag = B[WIDTH-1] ? -B : B;
    assign w_q_fix = r_neg_q ? -r_dvd : r_dvd;
    assign w_r_fix = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == IDLE && START) begin
            r_neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
            r_neg_r <= A[WIDTH-1];
        end
    end
`else
    assign w_a_mag = A;
    assign w_b_mag = B;
    assign w_q_fix = r_dvd;
    assign w_r_fix = r_rem;
`endif

    // The dividend register shifts out its MSB each step and shifts in the quotient bit.
    assign w_shift = {r_rem, r_dvd[WIDTH-1]};

    div_sub_step #(.WIDTH(WIDTH)) u_step (
        .i_remainder  (w_shift),
        .i_divisor    (r_dvs),
        .o_difference (w_diff),
        .o_borrow     (w_borrow)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_dvd   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (START) begin
                    r_dvd   <= w_a_mag;
                    r_dvs   <= w_b_mag;
                    r_cnt   <= CW'(WIDTH - 1);
                    r_busy  <= 1'b1;
                    r_zero  <= (B == '0);
                    r_rem   <= (B == '0) ? A : '0;
                    r_state <= (B == '0) ? FIN : CALC;
                end
                CALC: begin
                    r_dvd <= {r_dvd[WIDTH-2:0], ~w_borrow};
                    r_rem <= WIDTH'(w_borrow ? w_shift : w_diff);
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0)
                        r_state <= FIN;
                end
                FIN: begin
                    r_q     <= r_zero ? '1 : w_q_fix;
                    r_r     <= r_zero ? r_rem : w_r_fix;
                    r_div0  <= r_zero;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Q    = r_q;
    assign R    = r_r;
    assign BUSY = r_busy;
    assign DONE = r_done;
    assign DIV0 = r_div0;

endmodule
